// File: rtl/uart_rx_deser.sv
// UART receive deserializer: 16x oversampled start/data/parity/stop framing with
// glitch rejection, parity/framing/break detection and a one-cycle write strobe.
module uart_rx_deser #(
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       baud_tick,
    input  logic       rxd,
    input  logic       uart_en,
    input  logic [1:0] wlen,
    input  logic       parity_en,
    input  logic       even_parity,
    output logic [7:0] wdata,
    output logic       wdata_valid,
    output logic       framing_err,
    output logic       parity_err,
    output logic       break_err,
    output logic       busy
);

    localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] MID_TICK  = 4'((OVERSAMPLE / 2) - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_START    = 3'd1,
        S_DATA     = 3'd2,
        S_PARITY   = 3'd3,
        S_STOP     = 3'd4,
        S_BRK_WAIT = 3'd5
    } state_t;

    state_t     state_q, state_d;
    logic       rxd_meta_q, rxd_s_q;
    logic [3:0] tick_q, tick_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic       par_bit_q, par_bit_d;
    logic [1:0] wlen_q, wlen_d;
    logic       par_en_q, par_en_d;
    logic       even_q, even_d;
    logic [7:0] wdata_q, wdata_d;
    logic       valid_q, valid_d;
    logic       fe_q, fe_d;
    logic       pe_q, pe_d;
    logic       be_q, be_d;
    logic       busy_q;
    logic       full_s, mid_s, is_break_s;

    assign full_s = baud_tick && (tick_q == LAST_TICK);
    assign mid_s  = baud_tick && (tick_q == MID_TICK);

    // Next-state, frame capture and character status decode
    always_comb begin
        state_d    = state_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        par_bit_d  = par_bit_q;
        wlen_d     = wlen_q;
        par_en_d   = par_en_q;
        even_d     = even_q;
        wdata_d    = wdata_q;
        valid_d    = 1'b0;
        fe_d       = fe_q;
        pe_d       = pe_q;
        be_d       = be_q;
        is_break_s = (shift_q == 8'h00) && !(par_en_q && par_bit_q) && !rxd_s_q;
        if (uart_en) begin
            case (state_q)
                S_IDLE: begin
                    if (!rxd_s_q) begin
                        state_d   = S_START;
                        wlen_d    = wlen;
                        par_en_d  = parity_en;
                        even_d    = even_parity;
                        bit_d     = 3'd0;
                        shift_d   = 8'h00;
                        par_bit_d = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_START: begin
                    if (mid_s) begin
                        state_d = rxd_s_q ? S_IDLE : S_DATA;
                    end else begin
                        state_d = S_START;
                    end
                end
                S_DATA: begin
                    if (full_s) begin
                        shift_d[bit_q] = rxd_s_q;
                        if (bit_q == ({1'b0, wlen_q} + 3'd4)) begin
                            state_d = par_en_q ? S_PARITY : S_STOP;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end else begin
                        state_d = S_DATA;
                    end
                end
                S_PARITY: begin
                    if (full_s) begin
                        par_bit_d = rxd_s_q;
                        state_d   = S_STOP;
                    end else begin
                        state_d = S_PARITY;
                    end
                end
                S_STOP: begin
                    if (full_s) begin
                        valid_d = 1'b1;
                        fe_d    = !rxd_s_q;
                        be_d    = is_break_s;
                        // odd parity flips the sense: the XOR must come out 1
                        pe_d    = par_en_q & (^shift_q ^ par_bit_q ^ ~even_q);
                        wdata_d = is_break_s ? 8'h00 : shift_q;
                        state_d = is_break_s ? S_BRK_WAIT : S_IDLE;
                    end else begin
                        state_d = S_STOP;
                    end
                end
                S_BRK_WAIT: begin
                    if (baud_tick && rxd_s_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_BRK_WAIT;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else begin
            state_d = S_IDLE;
        end
        if (state_d != state_q) begin
            tick_d = 4'd0;
        end else if (baud_tick) begin
            tick_d = tick_q + 4'd1;
        end else begin
            tick_d = tick_q;
        end
    end

    // Line synchronizer, state/counter registers and registered outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            rxd_meta_q <= 1'b1;
            rxd_s_q    <= 1'b1;
            state_q    <= S_IDLE;
            tick_q     <= 4'd0;
            bit_q      <= 3'd0;
            shift_q    <= 8'h00;
            par_bit_q  <= 1'b0;
            wlen_q     <= 2'b00;
            par_en_q   <= 1'b0;
            even_q     <= 1'b0;
            wdata_q    <= 8'h00;
            valid_q    <= 1'b0;
            fe_q       <= 1'b0;
            pe_q       <= 1'b0;
            be_q       <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            rxd_meta_q <= rxd;
            rxd_s_q    <= rxd_meta_q;
            state_q    <= state_d;
            tick_q     <= tick_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            par_bit_q  <= par_bit_d;
            wlen_q     <= wlen_d;
            par_en_q   <= par_en_d;
            even_q     <= even_d;
            wdata_q    <= wdata_d;
            valid_q    <= valid_d;
            fe_q       <= fe_d;
            pe_q       <= pe_d;
            be_q       <= be_d;
            busy_q     <= (state_d != S_IDLE);
        end
    end

    assign wdata       = wdata_q;
    assign wdata_valid = valid_q;
    assign framing_err = fe_q;
    assign parity_err  = pe_q;
    assign break_err   = be_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_deser.sv
// Directed bench for uart_rx_deser: serial frames are driven bit by bit, expected
// characters are queued at send time and checked when wdata_valid fires.
module tb_uart_rx_deser;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       baud_tick = 1'b0;
    logic       rxd = 1'b1;
    logic       uart_en = 1'b1;
    logic [1:0] wlen = 2'b11;
    logic       parity_en = 1'b0;
    logic       even_parity = 1'b0;
    logic [7:0] wdata;
    logic       wdata_valid, framing_err, parity_err, break_err, busy;

    typedef struct packed {
        logic [7:0] d;
        logic       fe;
        logic       pe;
        logic       be;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   tick_cyc = -100;

    uart_rx_deser #(.OVERSAMPLE(16)) dut (
        .CLK(CLK), .RST(RST), .baud_tick(baud_tick), .rxd(rxd), .uart_en(uart_en),
        .wlen(wlen), .parity_en(parity_en), .even_parity(even_parity),
        .wdata(wdata), .wdata_valid(wdata_valid), .framing_err(framing_err),
        .parity_err(parity_err), .break_err(break_err), .busy(busy)
    );

    always #5 CLK = ~CLK;

    // one baud_tick every 4 clocks
    initial begin : tick_gen
        forever begin
            repeat (3) @(posedge CLK);
            #1 baud_tick = 1'b1;
            @(posedge CLK);
            #1 baud_tick = 1'b0;
        end
    end

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (baud_tick) tick_cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge CLK) begin : monitor
        exp_t e;
        if (wdata_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("wdata", {24'd0, wdata}, {24'd0, e.d});
                check("framing_err", {31'd0, framing_err}, {31'd0, e.fe});
                check("parity_err", {31'd0, parity_err}, {31'd0, e.pe});
                check("break_err", {31'd0, break_err}, {31'd0, e.be});
                check("latency", 32'(cyc - tick_cyc), 32'd0);
            end
        end
    end

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            do @(posedge CLK); while (baud_tick !== 1'b1);
        end
        #2;
    endtask

    // abort_kind: 1 = RST pulse, 2 = uart_en low; abort_at < 0 sends the whole frame
    task automatic send_frame(input logic [7:0] d, input int nbits, input bit pen,
                              input bit pbit, input bit stop_v, input int stop_ticks,
                              input int idle_ticks, input int abort_at, input int abort_kind);
        rxd = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < nbits; i++) begin
            if (i == abort_at) begin
                rxd = 1'b1;
                if (abort_kind == 1) begin
                    RST = 1'b1;
                    repeat (3) @(posedge CLK);
                    #1 RST = 1'b0;
                    check("rst_abort_busy", {31'd0, busy}, 32'd0);
                end else begin
                    uart_en = 1'b0;
                    @(posedge CLK);
                    #1 check("en_abort_busy", {31'd0, busy}, 32'd0);
                    repeat (2) @(posedge CLK);
                    #1 uart_en = 1'b1;
                end
                wait_ticks(20);
                check("abort_idle_busy", {31'd0, busy}, 32'd0);
                return;
            end
            rxd = d[i];
            wait_ticks(16);
        end
        if (pen) begin
            rxd = pbit;
            wait_ticks(16);
        end
        rxd = stop_v;
        wait_ticks(stop_ticks);
        rxd = 1'b1;
        if (idle_ticks > 0) wait_ticks(idle_ticks);
    endtask

    initial begin : stim
        repeat (4) @(posedge CLK);
        #1;
        check("rst_wdata", {24'd0, wdata}, 32'd0);
        check("rst_valid", {31'd0, wdata_valid}, 32'd0);
        check("rst_fe", {31'd0, framing_err}, 32'd0);
        check("rst_pe", {31'd0, parity_err}, 32'd0);
        check("rst_be", {31'd0, break_err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        RST = 1'b0;
        wait_ticks(4);

        // 8N1 0xA5, then the character must hold
        sb_q.push_back('{d: 8'hA5, fe: 1'b0, pe: 1'b0, be: 1'b0});
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 16, 20, -1, 0);
        check("hold_wdata", {24'd0, wdata}, 32'hA5);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // 5-bit even parity with wrong parity bit, then odd parity with correct bit
        wlen = 2'b00; parity_en = 1'b1; even_parity = 1'b1;
        sb_q.push_back('{d: 8'h13, fe: 1'b0, pe: 1'b1, be: 1'b0});
        send_frame(8'h13, 5, 1'b1, 1'b0, 1'b1, 16, 20, -1, 0);
        even_parity = 1'b0;
        sb_q.push_back('{d: 8'h13, fe: 1'b0, pe: 1'b0, be: 1'b0});
        send_frame(8'h13, 5, 1'b1, 1'b0, 1'b1, 16, 20, -1, 0);

        // framing error without break
        wlen = 2'b11; parity_en = 1'b0;
        sb_q.push_back('{d: 8'h55, fe: 1'b1, pe: 1'b0, be: 1'b0});
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 10, 20, -1, 0);

        // break: line held low well past the stop bit
        sb_q.push_back('{d: 8'h00, fe: 1'b1, pe: 1'b0, be: 1'b1});
        rxd = 1'b0;
        wait_ticks(200);
        check("brk_busy_low", {31'd0, busy}, 32'd1);
        rxd = 1'b1;
        wait_ticks(4);
        check("brk_busy_released", {31'd0, busy}, 32'd0);
        wait_ticks(10);

        // start glitch of 4 ticks
        rxd = 1'b0;
        wait_ticks(2);
        check("glitch_busy", {31'd0, busy}, 32'd1);
        wait_ticks(2);
        rxd = 1'b1;
        wait_ticks(5);
        check("glitch_rejected", {31'd0, busy}, 32'd0);
        wait_ticks(10);

        // back-to-back frames
        sb_q.push_back('{d: 8'h01, fe: 1'b0, pe: 1'b0, be: 1'b0});
        sb_q.push_back('{d: 8'hFF, fe: 1'b0, pe: 1'b0, be: 1'b0});
        send_frame(8'h01, 8, 1'b0, 1'b0, 1'b1, 16, 0, -1, 0);
        send_frame(8'hFF, 8, 1'b0, 1'b0, 1'b1, 16, 20, -1, 0);

        // aborted frames followed by good ones
        send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1, 16, 20, 3, 1);
        sb_q.push_back('{d: 8'h3C, fe: 1'b0, pe: 1'b0, be: 1'b0});
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1, 16, 20, -1, 0);
        send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1, 16, 20, 5, 2);
        sb_q.push_back('{d: 8'h3C, fe: 1'b0, pe: 1'b0, be: 1'b0});
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1, 16, 20, -1, 0);

        check("all_expected_received", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_deser.md
UART_RX_DESER -- requirements
Module: uart_rx_deser

Interface
REQ-001 Parameter: OVERSAMPLE, default 16, baud_tick pulses per bit period; the only supported value is 16.
REQ-002 CLK  input  1  single clock; all state changes on posedge CLK.
REQ-003 RST  input  1  reset; synchronous and active-high.
REQ-004 baud_tick  input  1  one-CLK pulse at 16x baud rate.
REQ-005 rxd  input  1  asynchronous serial line; idles high.
REQ-006 uart_en  input  1  1 = receiver enabled.
REQ-007 wlen  input  2  word length: 00=5, 01=6, 10=7, 11=8 bits.
REQ-008 parity_en  input  1  1 = parity bit present after the data bits.
REQ-009 even_parity  input  1  1 = even parity, 0 = odd parity.
REQ-010 wdata  output  8  received character, LSB-first; unused upper bits are 0.
REQ-011 wdata_valid  output  1  one-CLK pulse; drives the write side of the downstream rx FIFO.
REQ-012 framing_err, parity_err, break_err  output  1 each  status for the character; valid whenever wdata_valid=1.
REQ-013 busy  output  1  1 whenever the state is not IDLE.

Function
REQ-014 rxd SHALL pass through a 2-flop synchronizer (rxd_s); both flops reset to 1.
REQ-015 State machine SHALL have states IDLE, START, DATA, PARITY, STOP, BRK_WAIT.
REQ-016 A 4-bit tick counter SHALL increment on each baud_tick, wrap 15->0, and clear on every state transition.
REQ-017 A 3-bit bit counter SHALL count received data bits.
REQ-018 IDLE -> START SHALL occur when rxd_s=0 and uart_en=1.
REQ-019 START: on the 8th tick (counter=7), rxd_s=1 SHALL return to IDLE as a glitch, with no output; rxd_s=0 SHALL go to DATA.
REQ-020 DATA: every 16th tick SHALL sample rxd_s into the shift register, LSB first.
REQ-021 DATA exit: after wlen+5 bits, SHALL go to PARITY if parity_en=1, else to STOP.
REQ-022 PARITY: on the 16th tick SHALL sample the parity bit.
REQ-023 Parity check: parity_err=1 when the XOR of the data bits and the parity bit is 1 (even) or 0 (odd).
REQ-024 parity_err SHALL be 0 when parity_en=0.
REQ-025 STOP: on the 16th tick SHALL sample the stop bit; framing_err=1 if it is 0.
REQ-026 wdata, all three error outputs and wdata_valid SHALL update in the CLK cycle after that stop-sample tick (latency 1 CLK).
REQ-027 wdata and the error outputs SHALL hold their values until the next wdata_valid.
REQ-028 Break condition: data=0, parity bit=0 (if enabled) and stop=0.
REQ-029 On break: break_err=1, framing_err=1, wdata=0x00, next state BRK_WAIT.
REQ-030 No break: next state IDLE, with back-to-back start detection allowed in the next cycle.
REQ-031 BRK_WAIT SHALL stay until rxd_s=1, then go to IDLE.
REQ-032 uart_en=0 SHALL force IDLE from any state within 1 CLK, abort any partial frame, and produce no wdata_valid.
REQ-033 Configuration inputs SHALL be sampled on entry to START and held for the whole frame.
REQ-034 Ticks SHALL be ignored when baud_tick=0; the state machine advances only on ticks, except at the IDLE start detect and at uart_en.

Reset
REQ-035 RST=1 SHALL force IDLE, clear both counters, and set wdata=0x00, wdata_valid=0, framing_err=0, parity_err=0, break_err=0, busy=0.
REQ-036 RST mid-frame SHALL discard the partial character with no wdata_valid; reception resumes at the next falling edge after RST=0.

Verification
REQ-037 8N1, rxd frame for 0xA5 -> exactly one wdata_valid pulse, wdata=0xA5, all errors 0, 1 CLK after the stop-sample tick.
REQ-038 wlen=00, parity_en=1, even, data 0x13 with wrong parity bit -> wdata=0x13, parity_err=1, framing_err=0.
REQ-039 8N1 with stop bit held 0 on data 0x55 -> framing_err=1, break_err=0; all-zero frame -> break_err=1, busy stays 1 until rxd returns high.
REQ-040 rxd low pulse of 4 ticks in IDLE -> no wdata_valid, busy returns to 0 by tick 8.
REQ-041 Two back-to-back 8N1 frames 0x01, 0xFF -> two pulses, with correct wdata for each.
REQ-042 RST=1 or uart_en=0 asserted in DATA -> no wdata_valid; a following 0x3C frame is received correctly.
